funcunit_pipe: RTL and testbench

//  Registered, parametrised successor to the 16-bit function unit of the datapath.
//  - Executes one of 16 FS operations on A/B and returns D plus V/C/N/Z flags.
//  - Takes operands and returns results over valid/ready handshakes, so it sits between the register-file read stage and write-back.
//  - Flags are computed from the produced result; the unit stalls cleanly under backpressure.

---
 rtl/funcunit_pkg.sv | 32 +++
 rtl/funcunit_pipe_if.sv | 27 ++
 rtl/funcunit_core.sv | 69 ++++++
 rtl/funcunit_pipe.sv | 128 ++++++++++++
 tb/tb_funcunit_pipe.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/funcunit_pkg.sv
// Shared types for the pipelined function unit: function-select codes and the flag bundle.
package funcunit_pkg;

  typedef enum logic [3:0] {
    FS_TRANSFER = 4'b0000,
    FS_INC      = 4'b0001,
    FS_ADD      = 4'b0010,
    FS_ADD_INC  = 4'b0011,
    FS_ADD_NOTB = 4'b0100,
    FS_SUB      = 4'b0101,
    FS_DEC      = 4'b0110,
    FS_PASS_A   = 4'b0111,
    FS_AND      = 4'b1000,
    FS_OR       = 4'b1001,
    FS_XOR      = 4'b1010,
    FS_NOT      = 4'b1011,
    FS_MOVB     = 4'b1100,
    FS_SHR      = 4'b1101,
    FS_SHL      = 4'b1110,
    FS_LAST     = 4'b1111
  } fs_t;

  localparam logic [3:0] FS_ARITH_MAX = 4'b0111;

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } flags_t;

endpackage

// File: rtl/funcunit_pipe_if.sv
// Operand/result handshake bundle between the register-file read stage, the unit and write-back.
interface funcunit_pipe_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             IN_VALID;
  logic             IN_READY;
  logic [3:0]       FS;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] D;
  logic             V;
  logic             C;
  logic             N;
  logic             Z;

  modport master (
    output IN_VALID, FS, A, B, OUT_READY,
    input  IN_READY, OUT_VALID, D, V, C, N, Z
  );

  modport slave (
    input  IN_VALID, FS, A, B, OUT_READY,
    output IN_READY, OUT_VALID, D, V, C, N, Z
  );
endinterface

// File: rtl/funcunit_core.sv
// Combinational datapath: one of 16 operations on A/B (or the LAST value) plus V/C/N/Z flags.
module funcunit_core
  import funcunit_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [3:0]       fs_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] last_i,
  output logic [WIDTH-1:0] d_o,
  output flags_t           flags_o
);

  logic [WIDTH-1:0] x;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             carry_into_msb;
  logic [WIDTH-1:0] res;
  logic             res_v;
  logic             res_c;

  // Arithmetic codes select the second adder operand and carry-in from fs[2:0].
  always_comb begin
    x   = '0;
    cin = 1'b0;
    case (fs_i[2:0])
      3'b001:  cin = 1'b1;
      3'b010:  x = b_i;
      3'b011:  begin x = b_i;  cin = 1'b1; end
      3'b100:  x = ~b_i;
      3'b101:  begin x = ~b_i; cin = 1'b1; end
      3'b110:  x = '1;
      default: x = '0;
    endcase
  end

  assign sum            = {1'b0, a_i} + {1'b0, x} + {{WIDTH{1'b0}}, cin};
  assign carry_into_msb = sum[WIDTH-1] ^ a_i[WIDTH-1] ^ x[WIDTH-1];

  always_comb begin
    res   = sum[WIDTH-1:0];
    res_v = 1'b0;
    res_c = 1'b0;
    if (fs_i <= FS_ARITH_MAX) begin
      res_c = sum[WIDTH];
      res_v = carry_into_msb ^ sum[WIDTH];
    end else begin
      case (fs_t'(fs_i))
        FS_AND:  res = a_i & b_i;
        FS_OR:   res = a_i | b_i;
        FS_XOR:  res = a_i ^ b_i;
        FS_NOT:  res = ~a_i;
        FS_MOVB: res = b_i;
        FS_SHR:  begin res = {1'b0, b_i[WIDTH-1:1]}; res_c = b_i[0]; end
        FS_SHL:  begin res = {b_i[WIDTH-2:0], 1'b0}; res_c = b_i[WIDTH-1]; end
        FS_LAST: res = last_i;
        default: res = sum[WIDTH-1:0];
      endcase
    end
  end

  assign d_o       = res;
  assign flags_o.v = res_v;
  assign flags_o.c = res_c;
  assign flags_o.n = res[WIDTH-1];
  assign flags_o.z = (res == '0);

endmodule

// File: rtl/funcunit_pipe.sv
// Registered function unit with valid/ready handshakes and a LAST result register.
// FUNCUNIT_PIPE2_EN adds an operand register stage (latency 2, throughput 1/cycle).
module funcunit_pipe
  import funcunit_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic           CLK,
  input logic           RESET_N,
  funcunit_pipe_if.slave bus
);

  logic             src_valid;
  logic             src_ready;
  logic             src_take;
  logic [3:0]       src_fs;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] d_q, d_d;
  flags_t           flags_q, flags_d;
  logic [WIDTH-1:0] last_q, last_d;

  logic [WIDTH-1:0] core_d;
  flags_t           core_flags;

  assign src_ready = !out_valid_q | bus.OUT_READY;
  assign src_take  = src_valid & src_ready;

`ifdef FUNCUNIT_PIPE2_EN
  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_fs_q, s1_fs_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;

  assign bus.IN_READY = !s1_valid_q | src_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_fs_d    = s1_fs_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (bus.IN_READY) begin
      s1_valid_d = bus.IN_VALID;
      if (bus.IN_VALID) begin
        s1_fs_d = bus.FS;
        s1_a_d  = bus.A;
        s1_b_d  = bus.B;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      s1_valid_q <= 1'b0;
      s1_fs_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_fs_q    <= s1_fs_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
    end
  end

  // Executing at stage-2 entry means LAST always sees the op just ahead of it.
  assign src_valid = s1_valid_q;
  assign src_fs    = s1_fs_q;
  assign src_a     = s1_a_q;
  assign src_b     = s1_b_q;
`else
  assign bus.IN_READY = src_ready;
  assign src_valid    = bus.IN_VALID;
  assign src_fs       = bus.FS;
  assign src_a        = bus.A;
  assign src_b        = bus.B;
`endif

  funcunit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .fs_i    (src_fs),
    .a_i     (src_a),
    .b_i     (src_b),
    .last_i  (last_q),
    .d_o     (core_d),
    .flags_o (core_flags)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    d_d         = d_q;
    flags_d     = flags_q;
    last_d      = last_q;
    if (src_ready) begin
      out_valid_d = src_valid;
    end
    if (src_take) begin
      d_d     = core_d;
      flags_d = core_flags;
      last_d  = core_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      out_valid_q <= 1'b0;
      d_q         <= '0;
      flags_q     <= '0;
      last_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      d_q         <= d_d;
      flags_q     <= flags_d;
      last_q      <= last_d;
    end
  end

  assign bus.OUT_VALID = out_valid_q;
  assign bus.D         = d_q;
  assign bus.V         = flags_q.v;
  assign bus.C         = flags_q.c;
  assign bus.N         = flags_q.n;
  assign bus.Z         = flags_q.z;

endmodule

// File: tb/tb_funcunit_pipe.sv
// Scoreboard bench for funcunit_pipe: directed vectors plus a randomized handshake stream.
module tb_funcunit_pipe;
  localparam int unsigned W = 16;
`ifdef FUNCUNIT_PIPE2_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif
  localparam longint Full = longint'(1) << W;
  localparam longint Half = longint'(1) << (W - 1);

  typedef struct {
    logic [W-1:0] d;
    logic [3:0]   f;
    logic         has_k;
    logic [W-1:0] kd;
    logic [3:0]   kf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  funcunit_pipe_if #(.WIDTH(W)) bus ();

  funcunit_pipe #(
    .WIDTH (W)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  exp_t         exp_q[$];
  exp_t         e;
  int           tests = 0;
  int           fails = 0;
  int           accepted = 0;
  int           produced = 0;
  logic [W-1:0] m_last = '0;
  logic         cur_has_k = 1'b0;
  logic [W-1:0] cur_kd = '0;
  logic [3:0]   cur_kf = '0;
  logic [W-1:0] md;
  logic [3:0]   mf;

  // Reference: signed/unsigned integer arithmetic straight from the operation table.
  function automatic void model(input logic [3:0] fs, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] last, output logic [W-1:0] d,
                                output logic [3:0] f);
    longint ua, ub, x, cin, s, sa, sx, ss;
    logic v, c;
    ua = longint'(a);
    ub = longint'(b);
    v = 1'b0;
    c = 1'b0;
    x = 0;
    cin = 0;
    d = '0;
    if (fs < 4'd8) begin
      case (fs)
        4'd1: cin = 1;
        4'd2: x = ub;
        4'd3: begin x = ub; cin = 1; end
        4'd4: x = Full - 1 - ub;
        4'd5: begin x = Full - 1 - ub; cin = 1; end
        4'd6: x = Full - 1;
        default: x = 0;
      endcase
      s  = ua + x + cin;
      d  = s[W-1:0];
      c  = (s >= Full);
      sa = (ua >= Half) ? ua - Full : ua;
      sx = (x >= Half) ? x - Full : x;
      ss = sa + sx + cin;
      v  = (ss > Half - 1) || (ss < -Half);
    end else begin
      case (fs)
        4'd8:  d = a & b;
        4'd9:  d = a | b;
        4'd10: d = a ^ b;
        4'd11: d = ~a;
        4'd12: d = b;
        4'd13: begin s = ub / 2; d = s[W-1:0]; c = (ub % 2) == 1; end
        4'd14: begin s = (ub * 2) % Full; d = s[W-1:0]; c = (ub >= Half); end
        default: d = last;
      endcase
    end
    f = {v, c, d[W-1], d == '0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor/scoreboard: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_last = '0;
    end else begin
      if (bus.OUT_VALID && bus.OUT_READY) begin
        produced++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_result: got D=%h, expected no output", bus.D);
        end else begin
          e = exp_q.pop_front();
          if ({bus.D, bus.V, bus.C, bus.N, bus.Z} !== {e.d, e.f}) begin
            fails++;
            $display("FAIL model_result: got D=%h VCNZ=%b, expected D=%h VCNZ=%b",
                     bus.D, {bus.V, bus.C, bus.N, bus.Z}, e.d, e.f);
          end
          if (e.has_k) begin
            tests++;
            if ({bus.D, bus.V, bus.C, bus.N, bus.Z} !== {e.kd, e.kf}) begin
              fails++;
              $display("FAIL vector: got D=%h VCNZ=%b, expected D=%h VCNZ=%b",
                       bus.D, {bus.V, bus.C, bus.N, bus.Z}, e.kd, e.kf);
            end
          end
        end
      end
      if (bus.IN_VALID && bus.IN_READY) begin
        model(bus.FS, bus.A, bus.B, m_last, md, mf);
        m_last = md;
        exp_q.push_back('{d: md, f: mf, has_k: cur_has_k, kd: cur_kd, kf: cur_kf});
        accepted++;
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepts the op.
  task automatic send(input logic [3:0] fs, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic hk, input logic [W-1:0] kd, input logic [3:0] kf);
    int n;
    n = 0;
    bus.IN_VALID = 1'b1;
    bus.FS = fs;
    bus.A = a;
    bus.B = b;
    cur_has_k = hk;
    cur_kd = kd;
    cur_kf = kf;
    @(negedge clk);
    while (!bus.IN_READY && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.IN_READY) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got IN_READY=0 for 100 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    bus.IN_VALID = 1'b0;
    cur_has_k = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] edges[4];
    edges[0] = '0;
    edges[1] = '1;
    edges[2] = {1'b0, {(W-1){1'b1}}};
    edges[3] = {1'b1, {(W-1){1'b0}}};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    int start;
    int prod0;
    logic [W-1:0] snap_d;
    logic [3:0]   snap_f;

    bus.IN_VALID = 1'b0;
    bus.FS = '0;
    bus.A = '0;
    bus.B = '0;
    bus.OUT_READY = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("reset_d", 32'(bus.D), 32'd0);
    chk("reset_flags", 32'({bus.V, bus.C, bus.N, bus.Z}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", 32'(bus.IN_READY), 32'd1);

    // Signed overflow and latency.
    send(4'b0010, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'b1010);
    cyc = 1;
    while (!bus.OUT_VALID && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(Lat));

    // Subtract, decrement, shifts, LAST.
    send(4'b0101, 16'h0005, 16'h0005, 1'b1, 16'h0000, 4'b0101);
    send(4'b0110, 16'h8000, 16'h0000, 1'b1, 16'h7FFF, 4'b1100);
    send(4'b1101, 16'h0000, 16'h8001, 1'b1, 16'h4000, 4'b0100);
    send(4'b1110, 16'h0000, 16'h8001, 1'b1, 16'h0002, 4'b0100);
    send(4'b0010, 16'h1200, 16'h0034, 1'b1, 16'h1234, 4'b0000);
    send(4'b1111, 16'h0000, 16'h0000, 1'b1, 16'h1234, 4'b0000);
    repeat (Lat + 2) begin @(posedge clk); #1; end

    // Backpressure with two ops queued.
    prod0 = produced;
    bus.OUT_READY = 1'b0;
    send(4'b1000, 16'h00F0, 16'h0FF0, 1'b1, 16'h00F0, 4'b0000);
    fork
      send(4'b1001, 16'h1200, 16'h0034, 1'b1, 16'h1234, 4'b0000);
    join_none
    repeat (Lat) begin @(posedge clk); #1; end
    @(negedge clk);
    snap_d = bus.D;
    snap_f = {bus.V, bus.C, bus.N, bus.Z};
    chk("stall_first_d", 32'(snap_d), 32'h00F0);
    repeat (3) begin
      @(negedge clk);
      chk("stall_d", 32'(bus.D), 32'(snap_d));
      chk("stall_flags", 32'({bus.V, bus.C, bus.N, bus.Z}), 32'(snap_f));
      chk("stall_valid", 32'(bus.OUT_VALID), 32'd1);
      chk("stall_in_ready", 32'(bus.IN_READY), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.OUT_READY = 1'b1;
    wait fork;
    repeat (Lat + 2) begin @(posedge clk); #1; end
    chk("backpressure_count", 32'(produced - prod0), 32'd2);

    // Reset mid-operation.
    bus.OUT_READY = 1'b0;
    send(4'b0011, 16'h0001, 16'h0001, 1'b1, 16'h0003, 4'b0000);
    repeat (Lat - 1) begin @(posedge clk); #1; end
    chk("pre_reset_valid", 32'(bus.OUT_VALID), 32'd1);
    bus.IN_VALID = 1'b1;
    bus.FS = 4'b0010;
    bus.A = 16'h1111;
    bus.B = 16'h2222;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.IN_VALID = 1'b0;
    bus.OUT_READY = 1'b1;
    chk("mid_reset_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("mid_reset_d", 32'(bus.D), 32'd0);
    chk("mid_reset_flags", 32'({bus.V, bus.C, bus.N, bus.Z}), 32'd0);
    send(4'b1111, 16'hABCD, 16'h1234, 1'b1, 16'h0000, 4'b0001);
    repeat (Lat + 2) begin @(posedge clk); #1; end

    // Random stream.
    start = accepted;
    cyc = 0;
    while ((accepted - start) < 10000 && cyc < 80000) begin
      bus.IN_VALID = ($urandom_range(0, 3) != 0);
      bus.FS = 4'($urandom_range(0, 15));
      bus.A = pick();
      bus.B = pick();
      bus.OUT_READY = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.IN_VALID = 1'b0;
    bus.OUT_READY = 1'b1;
    chk("random_ops_issued", 32'((accepted - start) >= 10000), 32'd1);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    repeat (2) begin @(posedge clk); #1; end
    chk("drained", 32'(exp_q.size()), 32'd0);
    chk("all_results_seen", 32'(produced), 32'(accepted - 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
